mdu_ctrl: RTL and testbench



---
 rtl/mdu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Sequencer and datapath for the iterative multiply/divide unit in the EX stage.
// One op per accept, WIDTH iterations of shift-add or restoring divide, commit to HI/LO.
//
// state | meaning
// IDLE  | waiting for an E-stage mul/div op; stalls combinationally while accepting
// RUN   | one multiply/divide iteration per cycle, counter 0..WIDTH-1
// DONE  | signs applied; HI/LO written at the closing edge unless cancelled
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             cancel,
    output logic             stall_mdu,
    output logic             result_valid,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic             dz;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             sa;
    logic             sb;
    logic             start_ok;
    logic             div_zero_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    // opE[0]==0 selects the signed variants (MULT, DIV)
    assign sa          = !opE[0] && srcaE[WIDTH-1];
    assign sb          = !opE[0] && srcbE[WIDTH-1];
    assign abs_a       = sa ? (~srcaE + 1'b1) : srcaE;
    assign abs_b       = sb ? (~srcbE + 1'b1) : srcbE;
    assign start_ok    = startE && !cancel;
    assign div_zero_in = opE[1] && (srcbE == '0);

    // Multiply: acc_lo holds the multiplier and shifts in product low bits.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);

    // Divide: acc_lo holds the dividend and shifts in quotient bits.
    // A negative trial difference (top bit set) means restore.
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mag_b};

    assign prod   = {acc_hi, acc_lo};
    assign prod_s = neg_res ? (~prod + 1'b1) : prod;
    assign quo_s  = neg_res ? (~acc_lo + 1'b1) : acc_lo;
    assign rem_s  = neg_rem ? (~acc_hi + 1'b1) : acc_hi;

    always_comb begin
        stall_mdu    = 1'b0;
        result_valid = 1'b0;
        div_by_zero  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: stall_mdu = start_ok;
                RUN:  stall_mdu = !cancel;
                DONE: begin
                    result_valid = !cancel;
                    div_by_zero  = dz && !cancel;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            mag_a   <= '0;
            mag_b   <= '0;
            raw_a   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (cancel) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startE) begin
                        is_div  <= opE[1];
                        neg_res <= sa ^ sb;
                        neg_rem <= sa;
                        dz      <= div_zero_in;
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        raw_a   <= srcaE;
                        cnt     <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= opE[1] ? abs_a : abs_b;
                        state   <= div_zero_in ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (dz) begin
                        lo <= '1;
                        hi <= raw_a;
                    end else if (is_div) begin
                        lo <= quo_s;
                        hi <= rem_s;
                    end else begin
                        {hi, lo} <= prod_s;
                    end
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: the driver queues expected HI/LO per op,
// a monitor pops and compares on every result_valid strobe.
module tb_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        cancel;
    logic        stall_mdu;
    logic        result_valid;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    mdu_ctrl #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .startE       (startE),
        .opE          (opE),
        .srcaE        (srcaE),
        .srcbE        (srcbE),
        .cancel       (cancel),
        .stall_mdu    (stall_mdu),
        .result_valid (result_valid),
        .div_by_zero  (div_by_zero),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare strobe flags at the DONE cycle, HI/LO one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (div_by_zero && !result_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL dz_without_rv: got div_by_zero=1 expected 0");
            end
            if (result_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got result_valid=1 expected 0");
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_dz", {31'd0, div_by_zero}, {31'd0, e.dz});
                    @(negedge clk);
                    chk("sb_hi", hi, e.hi);
                    chk("sb_lo", lo, e.lo);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int estall);
        int n;
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        sb_q.push_back(e);
        issue(op, a, b);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (stall_mdu) n++;
            else break;
        end
        chk("stall_cycles", n, estall);
        chk("rv_at_done", {31'd0, result_valid}, 32'd1);
        // startE stays high across the DONE edge; it must not be re-accepted
        @(posedge clk);
        #1;
        startE = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_op", {31'd0, stall_mdu}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        startE = 1'b0;
        opE    = 2'b00;
        srcaE  = '0;
        srcbE  = '0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'd0, stall_mdu}, 32'd0);
        chk("rst_rv", {31'd0, result_valid}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(OP_MULTU, 32'd7, 32'd6, 32'h0, 32'h2A, 1'b0, 33);
        do_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        do_op(OP_MULT, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'h0, 32'd42, 1'b0, 33);
        do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        do_op(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
        do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33);
        do_op(OP_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1);
        do_op(OP_DIV, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1);

        // preload hi=0xAA, lo=0xBB
        do_op(OP_DIVU, 32'hBBAA, 32'h100, 32'hAA, 32'hBB, 1'b0, 33);

        // cancel during RUN iteration 10
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (11) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(negedge clk);
        chk("cancel_run_stall", {31'd0, stall_mdu}, 32'd0);
        chk("cancel_run_rv", {31'd0, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        startE = 1'b0;
        @(negedge clk);
        chk("cancel_run_idle", {31'd0, stall_mdu}, 32'd0);
        repeat (40) @(negedge clk);
        chk("cancel_run_hi", hi, 32'hAA);
        chk("cancel_run_lo", lo, 32'hBB);

        // cancel in the DONE cycle
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (33) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(negedge clk);
        chk("cancel_done_rv", {31'd0, result_valid}, 32'd0);
        chk("cancel_done_stall", {31'd0, stall_mdu}, 32'd0);
        @(posedge clk);
        #1;
        cancel = 1'b0;
        startE = 1'b0;
        repeat (3) @(negedge clk);
        chk("cancel_done_hi", hi, 32'hAA);
        chk("cancel_done_lo", lo, 32'hBB);

        // follow-up op proves the counter restarted cleanly
        do_op(OP_MULTU, 32'd11, 32'd13, 32'h0, 32'd143, 1'b0, 33);

        // asynchronous reset during RUN iteration 20
        issue(OP_MULTU, 32'h10, 32'h10);
        repeat (21) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'd0, stall_mdu}, 32'd0);
        chk("midrst_rv", {31'd0, result_valid}, 32'd0);
        chk("midrst_dz", {31'd0, div_by_zero}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        startE = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(OP_MULTU, 32'd3, 32'd3, 32'h0, 32'd9, 1'b0, 33);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
